// File: rtl/scard_pkg.sv
// Shared types and constants for the smartcard character path.
// Used by both the transmit and receive directions.
package scard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_ERRCHK,
    ST_GUARD,
    ST_ERRWAIT,
    ST_BACKOFF
  } scard_state_e;

  localparam int SCARD_DATA_BITS      = 8;
  localparam int SCARD_PARITY_BIT     = 9;
  localparam int SCARD_ERR_SAMPLE_ETU = 11;
  localparam int SCARD_BACKOFF_ETU    = 2;
  localparam int SCARD_SYNC_LAT       = 2;

  function automatic logic scard_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/scard_etu_timer.sv
// Elementary-time-unit counter with clear/load, end-of-ETU tick
// and a mid-ETU strobe for receive-side sampling.
module scard_etu_timer #(
  parameter int ETU_CYCLES = 372,
  parameter int CW = $clog2(ETU_CYCLES)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          en,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          etu_tick,
  output logic          mid_tick
);

  localparam logic [CW-1:0] LAST = CW'(ETU_CYCLES - 1);
  localparam logic [CW-1:0] MID  = CW'(ETU_CYCLES / 2 - 1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign etu_tick = en && (cnt == LAST);
  assign mid_tick = en && (cnt == MID);

endmodule

// File: rtl/scard_char_tx.sv
// T=0 character transmitter: start, 8 data LSB-first, even parity,
// guard-time error detection and bounded retransmission.
module scard_char_tx
  import scard_pkg::*;
#(
  parameter int ETU_CYCLES = 372,
  parameter int GUARD_ETU  = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  inout  wire        scard_io,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_fail,
  output logic       busy
);

  localparam int FRAME_CYC = (12 + GUARD_ETU) * ETU_CYCLES;
  localparam int FW = $clog2(FRAME_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int CW = $clog2(ETU_CYCLES);

  localparam logic [FW-1:0] ERR_AT =
    FW'(SCARD_ERR_SAMPLE_ETU * ETU_CYCLES + SCARD_SYNC_LAT);
  localparam logic [FW-1:0] GUARD_END = FW'(FRAME_CYC - 1);
  // Backoff is measured from the release on the line, not from io_s.
  localparam logic [FW-1:0] BACKOFF_END =
    FW'(SCARD_BACKOFF_ETU * ETU_CYCLES - SCARD_SYNC_LAT - 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  scard_state_e state, state_n;

  logic [7:0]    data_q;
  logic [RW-1:0] retry_q;
  logic          fail_pend;
  logic [3:0]    bit_idx;
  logic [FW-1:0] frame_q;
  logic [1:0]    sync_q;
  logic          io_s;

  logic          accept;
  logic          frame_clr;
  logic          retry_inc;
  logic          fail_set;
  logic          tx_phase;
  logic          drive_low;
  logic          etu_tick;
  logic [CW-1:0] etu_cnt;

  assign tx_phase = (state == ST_START) ||
                    (state == ST_DATA)  ||
                    (state == ST_PARITY);

  scard_etu_timer #(
    .ETU_CYCLES(ETU_CYCLES)
  ) u_etu (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en      (tx_phase),
    .clear   (frame_clr),
    .load    (1'b0),
    .load_val('0),
    .cnt     (etu_cnt),
    .etu_tick(etu_tick),
    .mid_tick()
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], scard_io};
    end
  end

  assign io_s = sync_q[1];

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    frame_clr = 1'b0;
    retry_inc = 1'b0;
    fail_set  = 1'b0;
    tx_done   = 1'b0;
    tx_fail   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          accept    = 1'b1;
          frame_clr = 1'b1;
          state_n   = ST_START;
        end
      end
      ST_START: begin
        if (etu_tick) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (etu_tick && bit_idx == 4'(SCARD_DATA_BITS))
          state_n = ST_PARITY;
      end
      ST_PARITY: begin
        if (etu_tick) state_n = ST_ERRCHK;
      end
      ST_ERRCHK: begin
        if (frame_q == ERR_AT) begin
          if (io_s) begin
            state_n = ST_GUARD;
          end else begin
            state_n = ST_ERRWAIT;
            if (retry_q < RETRY_MAX) retry_inc = 1'b1;
            else                     fail_set  = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (frame_q == GUARD_END) begin
          tx_done = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_ERRWAIT: begin
        if (io_s) begin
          frame_clr = 1'b1;
          state_n   = ST_BACKOFF;
        end
      end
      ST_BACKOFF: begin
        if (frame_q == BACKOFF_END) begin
          frame_clr = 1'b1;
          if (fail_pend) begin
            tx_fail = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_START;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      retry_q   <= '0;
      fail_pend <= 1'b0;
      bit_idx   <= '0;
      frame_q   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        data_q    <= tx_data;
        retry_q   <= '0;
        fail_pend <= 1'b0;
      end else if (tx_done) begin
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + RW'(1);
      end
      if (fail_set) fail_pend <= 1'b1;
      if (frame_clr)              frame_q <= '0;
      else if (state != ST_IDLE)  frame_q <= frame_q + FW'(1);
      if (frame_clr)     bit_idx <= '0;
      else if (etu_tick) bit_idx <= bit_idx + 4'd1;
    end
  end

  always_comb begin
    drive_low = 1'b0;
    if (tx_phase) begin
      unique case (1'b1)
        (bit_idx == 4'd0):
          drive_low = 1'b1;
        (bit_idx == 4'(SCARD_PARITY_BIT)):
          drive_low = !scard_parity(data_q);
        default:
          drive_low = !data_q[3'(bit_idx - 4'd1)];
      endcase
    end
  end

  assign scard_io = drive_low ? 1'b0 : 1'bz;
  assign tx_ready = (state == ST_IDLE);
  assign busy     = !tx_ready;

endmodule

// File: tb/tb_scard_char_tx.sv
// Directed bench for scard_char_tx with E=16, guard 2, 3 retries.
module tb_scard_char_tx;

  localparam int E = 16;
  localparam logic [9:0] FR_3B = 10'b1001110110;

  logic       clk;
  logic       reset_i;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_fail;
  logic       busy;
  logic       bench_low;
  wire        io;

  pullup (io);
  assign io = bench_low ? 1'b0 : 1'bz;

  scard_char_tx #(
    .ETU_CYCLES(E),
    .GUARD_ETU (2),
    .MAX_RETRY (3)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .scard_io(io),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done (tx_done),
    .tx_fail (tx_fail),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int f = 0;
  int err_mode = 0;
  int n_done = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_both = 0;

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_fail) n_fail++;
    if (tx_done && tx_fail) n_both++;
    if (tx_valid && tx_ready) n_acc++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic err_hit(input int x);
    int m;
    m = x % 216;
    if (err_mode == 1) return (x >= 168 && x <= 183);
    if (err_mode == 2) return (x < 864 && m >= 168 && m <= 183);
    return 1'b0;
  endfunction

  task automatic step_to(input int n);
    while (f < n) begin
      @(posedge clk);
      #1;
      f++;
      bench_low = err_hit(f);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic hold);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("accept_wait", int'(n < 2000), 1);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    f = 0;
    bench_low = 1'b0;
    #1;
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      step_to(base + k * E + 8);
      check($sformatf("%s_b%0d", tag, k), int'(io), int'(bits[k]));
    end
  endtask

  initial begin
    int bad;
    reset_i   = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    bench_low = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    #1;
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_fail", int'(tx_fail), 0);
    check("rst_io", int'(io), 1);

    // clean 0x3B
    n_done = 0; n_fail = 0;
    send(8'h3B, 1'b0);
    check("t1_lat", int'(io), 0);
    check("t1_busy", int'(busy), 1);
    check_frame("t1", 0, FR_3B);
    step_to(222);
    check("t1_done222", int'(tx_done), 0);
    step_to(223);
    check("t1_done223", int'(tx_done), 1);
    check("t1_rdy223", int'(tx_ready), 0);
    step_to(224);
    check("t1_rdy224", int'(tx_ready), 1);
    check("t1_done224", int'(tx_done), 0);
    step_to(240);
    check("t1_ndone", n_done, 1);
    check("t1_nfail", n_fail, 0);

    // single error on first attempt
    n_done = 0; n_fail = 0; err_mode = 1;
    send(8'h3B, 1'b0);
    check_frame("t2a", 0, FR_3B);
    step_to(200);
    check("t2_busy", int'(busy), 1);
    step_to(215);
    check("t2_io215", int'(io), 1);
    step_to(216);
    check("t2_io216", int'(io), 0);
    check_frame("t2b", 216, FR_3B);
    step_to(438);
    check("t2_done438", int'(tx_done), 0);
    step_to(439);
    check("t2_done439", int'(tx_done), 1);
    step_to(440);
    check("t2_rdy440", int'(tx_ready), 1);
    step_to(460);
    check("t2_ndone", n_done, 1);
    check("t2_nfail", n_fail, 0);
    err_mode = 0;

    // error on every attempt
    n_done = 0; n_fail = 0; err_mode = 2;
    send(8'h3B, 1'b0);
    for (int a = 0; a < 4; a++) begin
      if (a > 0) begin
        step_to(a * 216 - 1);
        check($sformatf("t3_pre%0d", a), int'(io), 1);
        step_to(a * 216);
        check($sformatf("t3_st%0d", a), int'(io), 0);
      end
      check_frame($sformatf("t3f%0d", a), a * 216, FR_3B);
    end
    step_to(862);
    check("t3_fail862", int'(tx_fail), 0);
    check("t3_busy862", int'(busy), 1);
    step_to(863);
    check("t3_fail863", int'(tx_fail), 1);
    check("t3_rdy863", int'(tx_ready), 0);
    step_to(864);
    check("t3_rdy864", int'(tx_ready), 1);
    step_to(880);
    check("t3_nfail", n_fail, 1);
    check("t3_ndone", n_done, 0);
    err_mode = 0;

    // back-to-back with valid held
    n_done = 0; n_acc = 0;
    send(8'h00, 1'b1);
    tx_data = 8'hFF;
    step_to(24);
    check("t4_d0a", int'(io), 0);
    step_to(152);
    check("t4_par_a", int'(io), 0);
    step_to(224);
    check("t4_io224", int'(io), 1);
    step_to(225);
    check("t4_io225", int'(io), 0);
    tx_valid = 1'b0;
    step_to(249);
    check("t4_d0b", int'(io), 1);
    step_to(377);
    check("t4_par_b", int'(io), 0);
    step_to(470);
    check("t4_nacc", n_acc, 1 + 1);
    check("t4_ndone", n_done, 2);

    // reset mid-frame
    n_done = 0; n_fail = 0;
    send(8'h00, 1'b0);
    step_to(80);
    check("t5_io_pre", int'(io), 0);
    reset_i = 1'b1;
    #1;
    check("t5_io_rst", int'(io), 1);
    check("t5_rdy_rst", int'(tx_ready), 1);
    check("t5_busy_rst", int'(busy), 0);
    step_to(83);
    reset_i = 1'b0;
    step_to(400);
    check("t5_rdy", int'(tx_ready), 1);
    check("t5_busy", int'(busy), 0);
    check("t5_io", int'(io), 1);
    check("t5_ndone", n_done, 0);
    check("t5_nfail", n_fail, 0);

    // long idle
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step_to(f + 1);
      if (io !== 1'b1 || busy) bad++;
    end
    check("t6_idle", bad, 0);
    check("excl", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
